// File: rtl/rocket_pkg.sv
// Shared constants and types for the rocket motion stage.
// Positions are signed fixed point with FRAC_BITS fractional bits.
package rocket_pkg;
    localparam int FRAC_BITS     = 6;
    localparam int SCREEN_TOP    = 0;
    localparam int SCREEN_BOTTOM = 479;
    localparam int ROCKET_H      = 16;
    localparam int COORD_W       = 11;
    localparam int POS_W         = COORD_W + FRAC_BITS;
    localparam int Y_MAX         = SCREEN_BOTTOM - ROCKET_H;

    typedef logic signed [POS_W-1:0] pos_fx_t;

    typedef enum logic [1:0] {
        IDLE,
        FLYING,
        SPENT
    } rocket_state_t;
endpackage

// File: rtl/single_rocket_mover_edge_detect.sv
// Single-register edge detector: rise/fall pulses for a level input.
module edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);
    logic d_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) d_q <= 1'b0;
        else       d_q <= d_i;
    end

    assign rise_o = d_i & ~d_q;
    assign fall_o = ~d_i & d_q;
endmodule

// File: rtl/single_rocket_mover.sv
// Per-rocket motion stage: latches launch values on isActive rise and steps
// the vertical fixed-point position once per frame until it would leave the screen.
module single_rocket_mover
    import rocket_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      startOfFrame,
    input  logic                      isActive,
    input  logic signed [COORD_W-1:0] initialSpeed,
    input  logic signed [COORD_W-1:0] initialX,
    input  logic signed [COORD_W-1:0] initialY,
    output logic signed [COORD_W-1:0] topLeftX,
    output logic signed [COORD_W-1:0] topLeftY,
    output logic                      rocketVisible,
    output logic                      reachedBorder
);
    // Legal accumulator window, one bit wider than the accumulator so the sum never wraps
    localparam logic signed [POS_W:0] NEXT_LO = (POS_W+1)'(SCREEN_TOP <<< FRAC_BITS);
    localparam logic signed [POS_W:0] NEXT_HI = (POS_W+1)'(((Y_MAX + 1) <<< FRAC_BITS) - 1);

    rocket_state_t             state_q, state_d;
    pos_fx_t                   acc_q, acc_d;
    logic signed [COORD_W-1:0] speed_q, speed_d;
    logic signed [COORD_W-1:0] x_q, x_d;
    logic                      vis_q, vis_d;
    logic                      border_q, border_d;

    logic                      rise, fall;
    logic signed [POS_W:0]     next_y;
    logic                      in_range;

    edge_detect u_edge (
        .clk    (clk),
        .reset  (reset),
        .d_i    (isActive),
        .rise_o (rise),
        .fall_o (fall)
    );

    always_comb begin
        next_y   = {acc_q[POS_W-1], acc_q} + {{(POS_W-COORD_W+1){speed_q[COORD_W-1]}}, speed_q};
        in_range = (next_y >= NEXT_LO) && (next_y <= NEXT_HI);

        state_d  = state_q;
        acc_d    = acc_q;
        speed_d  = speed_q;
        x_d      = x_q;
        vis_d    = vis_q;
        border_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (rise) begin
                    acc_d   = {initialY, {FRAC_BITS{1'b0}}};
                    speed_d = initialSpeed;
                    x_d     = initialX;
                    vis_d   = 1'b1;
                    state_d = FLYING;
                end
            end
            FLYING: begin
                // isActive is always 1 on the cycle before FLYING, so fall == !isActive here
                if (fall) begin
                    vis_d   = 1'b0;
                    state_d = IDLE;
                end else if (startOfFrame) begin
                    if (in_range) begin
                        acc_d = next_y[POS_W-1:0];
                    end else begin
                        border_d = 1'b1;
                        vis_d    = 1'b0;
                        state_d  = SPENT;
                    end
                end
            end
            SPENT: begin
                if (!isActive) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            speed_q  <= '0;
            x_q      <= '0;
            vis_q    <= 1'b0;
            border_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            speed_q  <= speed_d;
            x_q      <= x_d;
            vis_q    <= vis_d;
            border_q <= border_d;
        end
    end

    assign topLeftX      = x_q;
    assign topLeftY      = acc_q[POS_W-1:FRAC_BITS];
    assign rocketVisible = vis_q;
    assign reachedBorder = border_q;
endmodule

// File: tb/tb_single_rocket_mover.sv
// Directed scenarios plus random traffic against a cycle-level behavioural model.
module tb_single_rocket_mover;
    localparam int Y_LIM = (479 - 16) * 64 + 63;

    logic               clk = 1'b0;
    logic               reset;
    logic               startOfFrame;
    logic               isActive;
    logic signed [10:0] initialSpeed;
    logic signed [10:0] initialX;
    logic signed [10:0] initialY;
    logic signed [10:0] topLeftX;
    logic signed [10:0] topLeftY;
    logic               rocketVisible;
    logic               reachedBorder;

    int tests = 0;
    int fails = 0;

    // model: position in 1/64 px as a plain integer, flight phase as two flags
    int m_y64, m_sp, m_x;
    bit m_fly, m_spent, m_vis, m_pulse, m_prev;

    single_rocket_mover dut (
        .clk           (clk),
        .reset         (reset),
        .startOfFrame  (startOfFrame),
        .isActive      (isActive),
        .initialSpeed  (initialSpeed),
        .initialX      (initialX),
        .initialY      (initialY),
        .topLeftX      (topLeftX),
        .topLeftY      (topLeftY),
        .rocketVisible (rocketVisible),
        .reachedBorder (reachedBorder)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic signed [16:0] obs, input logic signed [16:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_y64 = 0; m_sp = 0; m_x = 0;
        m_fly = 0; m_spent = 0; m_vis = 0; m_pulse = 0; m_prev = 0;
    endtask

    task automatic model_step(input bit sof, input bit act, input int sp, input int ix, input int iy);
        bit rise;
        int ny;
        rise    = act && !m_prev;
        m_pulse = 0;
        if (m_fly) begin
            if (!act) begin
                m_fly = 0; m_vis = 0;
            end else if (sof) begin
                ny = m_y64 + m_sp;
                if (ny >= 0 && ny <= Y_LIM) m_y64 = ny;
                else begin
                    m_pulse = 1; m_vis = 0; m_fly = 0; m_spent = 1;
                end
            end
        end else if (m_spent) begin
            if (!act) m_spent = 0;
        end else if (rise) begin
            m_y64 = iy * 64; m_sp = sp; m_x = ix; m_fly = 1; m_vis = 1;
        end
        m_prev = act;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".x"},   topLeftX,      17'(m_x));
        chk({tag, ".y"},   topLeftY,      17'(m_y64 >>> 6));
        chk({tag, ".vis"}, rocketVisible, 17'(m_vis));
        chk({tag, ".rb"},  reachedBorder, 17'(m_pulse));
    endtask

    task automatic cyc(input string tag, input bit sof, input bit act, input int sp, input int ix, input int iy);
        startOfFrame = sof;
        isActive     = act;
        initialSpeed = 11'(sp);
        initialX     = 11'(ix);
        initialY     = 11'(iy);
        model_step(sof, act, sp, ix, iy);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic frames(input string tag, input int n, input int sp, input int ix, input int iy);
        for (int i = 0; i < n; i++) begin
            cyc(tag, 1'b1, 1'b1, sp, ix, iy);
            cyc(tag, 1'b0, 1'b1, sp, ix, iy);
        end
    endtask

    initial begin
        reset = 1'b1; startOfFrame = 1'b0; isActive = 1'b0;
        initialSpeed = '0; initialX = '0; initialY = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("rst");
        reset = 1'b0;

        // launch X=100 Y=400 speed -2 px/frame, 10 frames
        cyc("t2.launch", 1'b0, 1'b1, -128, 100, 400);
        chk("t2.vis_lat1", rocketVisible, 17'(1));
        chk("t2.y0", topLeftY, 17'(400));
        frames("t2", 10, -128, 100, 400);
        chk("t2.y10", topLeftY, 17'(380));
        chk("t2.x10", topLeftX, 17'(100));

        // reset mid-flight (asynchronous, between edges)
        #3;
        reset = 1'b1;
        isActive = 1'b0;
        #1;
        model_reset();
        check_all("t1.async");
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc("t1.rel", 1'b0, 1'b0, 0, 0, 0);
        chk("t1.rb", reachedBorder, 17'(0));
        chk("t1.y", topLeftY, 17'(0));

        // Y=200 speed +0.5 px/frame
        cyc("t3.launch", 1'b0, 1'b1, 32, 50, 200);
        frames("t3", 3, 32, 50, 200);
        chk("t3.y3", topLeftY, 17'(201));
        frames("t3", 1, 32, 50, 200);
        chk("t3.y4", topLeftY, 17'(202));
        cyc("t3.drop", 1'b0, 1'b0, 0, 0, 0);

        // top border crossing
        cyc("t4.launch", 1'b0, 1'b1, -128, 10, 4);
        cyc("t4.f1", 1'b1, 1'b1, -128, 10, 4);
        chk("t4.y1", topLeftY, 17'(2));
        cyc("t4.f2", 1'b1, 1'b1, -128, 10, 4);
        chk("t4.y2", topLeftY, 17'(0));
        cyc("t4.f3", 1'b1, 1'b1, -128, 10, 4);
        chk("t4.rb_hi", reachedBorder, 17'(1));
        chk("t4.y3", topLeftY, 17'(0));
        chk("t4.vis3", rocketVisible, 17'(0));
        cyc("t4.after", 1'b0, 1'b1, -128, 10, 4);
        chk("t4.rb_lo", reachedBorder, 17'(0));
        frames("t4.spent", 5, -128, 10, 4);
        chk("t4.rb_spent", reachedBorder, 17'(0));
        cyc("t4.drop", 1'b0, 1'b0, 0, 0, 0);

        // isActive falls together with a border-crossing frame
        cyc("t5.launch", 1'b0, 1'b1, -128, 0, 1);
        cyc("t5.hit", 1'b1, 1'b0, -128, 0, 1);
        chk("t5.rb", reachedBorder, 17'(0));
        chk("t5.vis", rocketVisible, 17'(0));

        // IDLE next cycle: a fresh launch is accepted, then re-fire is ignored
        cyc("t6.launch", 1'b0, 1'b1, 64, 20, 50);
        chk("t5.idle_relaunch", topLeftY, 17'(50));
        frames("t6", 1, 64, 20, 50);
        chk("t6.y1", topLeftY, 17'(51));
        cyc("t6.refire", 1'b0, 1'b1, -500, 7, 300);
        frames("t6.refire", 1, -500, 7, 300);
        chk("t6.y2", topLeftY, 17'(52));
        chk("t6.x2", topLeftX, 17'(20));
        cyc("t6.low", 1'b0, 1'b0, -500, 7, 300);
        cyc("t6.reload", 1'b0, 1'b1, -500, 7, 300);
        chk("t6.y_reload", topLeftY, 17'(300));
        chk("t6.x_reload", topLeftX, 17'(7));

        // random traffic
        begin
            bit act = 1'b1;
            for (int i = 0; i < 600; i++) begin
                int sp, ix, iy;
                bit sof;
                if ($urandom_range(0, 15) == 0) act = ~act;
                sof = ($urandom_range(0, 3) == 0);
                sp  = int'($urandom_range(0, 2047)) - 1024;
                ix  = int'($urandom_range(0, 2047)) - 1024;
                iy  = int'($urandom_range(0, 520)) - 20;
                cyc("rnd", sof, act, sp, ix, iy);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
